// File: rtl/uart_hex_formatter.sv
// Formats queued 16-bit samples as "0xABCD" + CR/LF text lines and streams
// them one byte at a time into a uart_tx that shares this clock.
module uart_hex_formatter #(
  parameter int DEPTH = 4,
  parameter bit CRLF  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     tx_next,
  output logic [7:0]               tx_word,
  output logic                     tx_hold,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] LAST_IDX = CRLF ? 3'd7 : 3'd6;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t         r_state;
  logic [2:0]     r_idx;
  logic [15:0]    r_line;
  logic           r_txHold;
  logic           r_busy;

  logic [15:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [CW-1:0]  r_count;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_accept;
  logic           w_lastByte;
  logic [7:0]     w_txWord;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign in_ready   = !rst && !w_full;
  assign w_push     = in_valid && in_ready;
  // uart_tx only latches a byte when hold is low, so accept implies SEND
  assign w_accept   = tx_next && !r_txHold;
  assign w_lastByte = (r_idx == LAST_IDX);
  assign w_pop      = !w_empty && ((r_state == IDLE) || (w_accept && w_lastByte));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Hold and busy are registered alongside the state so neither ever
  // depends combinationally on tx_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= 3'd0;
      r_line   <= 16'h0000;
      r_txHold <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_line   <= r_mem[r_rdPtr];
            r_idx    <= 3'd0;
            r_state  <= SEND;
            r_txHold <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        SEND: begin
          if (w_accept) begin
            if (!w_lastByte) begin
              r_idx <= r_idx + 3'd1;
            end else if (w_pop) begin
              r_line <= r_mem[r_rdPtr];
              r_idx  <= 3'd0;
            end else begin
              r_idx    <= 3'd0;
              r_state  <= IDLE;
              r_txHold <= 1'b1;
              r_busy   <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_txHold <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    w_txWord = 8'h00;
    if (r_state == SEND) begin
      case (r_idx)
        3'd0:    w_txWord = 8'h30;
        3'd1:    w_txWord = 8'h78;
        3'd2:    w_txWord = hexChar(r_line[15:12]);
        3'd3:    w_txWord = hexChar(r_line[11:8]);
        3'd4:    w_txWord = hexChar(r_line[7:4]);
        3'd5:    w_txWord = hexChar(r_line[3:0]);
        3'd6:    w_txWord = CRLF ? 8'h0D : 8'h0A;
        3'd7:    w_txWord = 8'h0A;
        default: w_txWord = 8'h00;
      endcase
    end
  end

  assign tx_word    = w_txWord;
  assign tx_hold    = r_txHold;
  assign busy       = r_busy;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Directed bench for uart_hex_formatter: a CRLF=1 instance for most scenarios
// and a CRLF=0 instance for the short-line format, both fed by a uart_tx model.
module tb_uart_hex_formatter;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_valid0;
  logic        tx_next;
  logic        txEnable;

  logic        in_ready, tx_hold, busy;
  logic [7:0]  tx_word;
  logic [2:0]  fifo_count;
  logic        in_ready0, tx_hold0, busy0;
  logic [7:0]  tx_word0;
  logic [2:0]  fifo_count0;

  int testsRun  = 0;
  int failCount = 0;
  int holdRises = 0;
  logic prevHold = 1'b1;
  int txPhase = 0;
  logic [7:0] got[$];
  logic [7:0] got0[$];

  typedef struct {
    logic [15:0] sample;
    logic [63:0] expLine;
  } vec_t;
  vec_t vecs[5];

  localparam logic [127:0] HEXTAB = "0123456789ABCDEF";

  uart_hex_formatter #(.DEPTH(4), .CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_next(tx_next), .tx_word(tx_word),
    .tx_hold(tx_hold), .busy(busy), .fifo_count(fifo_count)
  );

  uart_hex_formatter #(.DEPTH(4), .CRLF(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid0),
    .in_ready(in_ready0), .tx_next(tx_next), .tx_word(tx_word0),
    .tx_hold(tx_hold0), .busy(busy0), .fifo_count(fifo_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_tx stand-in: asks for a byte every third cycle; a byte counts as
  // taken when next is high and hold is low at the coming rising edge.
  always @(negedge clk) begin
    if (txEnable) begin
      txPhase = (txPhase + 1) % 3;
      tx_next = (txPhase == 0);
    end else begin
      txPhase = 0;
      tx_next = 1'b0;
    end
    if (!rst && tx_next) begin
      if (!tx_hold)  got.push_back(tx_word);
      if (!tx_hold0) got0.push_back(tx_word0);
    end
    if (tx_hold && !prevHold) holdRises++;
    prevHold = tx_hold;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got %0d bytes, required completion", got.size());
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] modelLine(input logic [15:0] s);
    logic [127:0] tab;
    logic [63:0]  v;
    tab = HEXTAB;
    v = {8'h30, 8'h78, 48'h0};
    for (int k = 0; k < 4; k++) begin
      v[47 - 8*k -: 8] = tab[(15 - int'(s[15 - 4*k -: 4])) * 8 +: 8];
    end
    v[15:0] = 16'h0D0A;
    return v;
  endfunction

  function automatic logic [63:0] lineFrom(input int start);
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) begin
      v = {v[55:0], (start + k < got.size()) ? got[start + k] : 8'h00};
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d);
    int n = 0;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    checkOutput("push_ready_timeout", {63'h0, in_ready}, 64'h1);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitBytes(input int target, input int budget, input string name);
    int n = 0;
    while (got.size() < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(got.size()), 64'(target));
  endtask

  initial begin
    int base;
    int riseBase;
    logic [63:0] v0;

    vecs[0] = '{16'hFFFF, 64'h3078464646460D0A};
    vecs[1] = '{16'h1234, 64'h3078313233340D0A};
    vecs[2] = '{16'hA5C3, 64'h3078413543330D0A};
    vecs[3] = '{16'h8000, 64'h3078383030300D0A};
    vecs[4] = '{16'h7F3B, 64'h3078374633420D0A};

    rst = 1'b1; in_data = 16'h0; in_valid = 1'b0; in_valid0 = 1'b0; txEnable = 1'b0;
    repeat (3) tick();
    checkOutput("rst_in_ready", {63'h0, in_ready}, 64'h0);
    checkOutput("rst_tx_hold", {63'h0, tx_hold}, 64'h1);
    checkOutput("rst_tx_word", {56'h0, tx_word}, 64'h00);
    checkOutput("rst_busy", {63'h0, busy}, 64'h0);
    checkOutput("rst_fifo_count", {61'h0, fifo_count}, 64'h0);
    checkOutput("rst_tx_hold0", {63'h0, tx_hold0}, 64'h1);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", {63'h0, in_ready}, 64'h1);

    // Latency of a single sample into an empty idle block.
    base = got.size();
    in_data = 16'hBEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("lat_count_E0", {61'h0, fifo_count}, 64'h1);
    checkOutput("lat_hold_E0", {63'h0, tx_hold}, 64'h1);
    tick();
    checkOutput("lat_hold_E1", {63'h0, tx_hold}, 64'h0);
    checkOutput("lat_word_E1", {56'h0, tx_word}, 64'h30);
    checkOutput("lat_busy_E1", {63'h0, busy}, 64'h1);
    checkOutput("lat_count_E1", {61'h0, fifo_count}, 64'h0);
    txEnable = 1'b1;
    waitBytes(base + 8, 200, "beef_bytes");
    checkOutput("beef_busy_fall", {63'h0, busy}, 64'h0);
    checkOutput("beef_hold_rise", {63'h0, tx_hold}, 64'h1);
    checkOutput("beef_line", lineFrom(base), 64'h3078424545460D0A);

    for (int i = 0; i < 5; i++) begin
      base = got.size();
      applyStimulus(vecs[i].sample);
      waitBytes(base + 8, 200, $sformatf("vec%0d_bytes", i));
      checkOutput($sformatf("vec%0d_line", i), lineFrom(base), vecs[i].expLine);
      checkOutput($sformatf("vec%0d_idle", i), {62'h0, tx_hold, busy}, 64'h2);
    end

    // Two lines back to back across the digit/letter boundaries.
    base = got.size();
    applyStimulus(16'h09AF);
    applyStimulus(16'h0000);
    waitBytes(base + 16, 400, "hexb_bytes");
    checkOutput("hexb_line0", lineFrom(base), 64'h3078303941460D0A);
    checkOutput("hexb_line1", lineFrom(base + 8), 64'h3078303030300D0A);

    // Backpressure: six pushes with the serial side stalled.
    txEnable = 1'b0;
    repeat (5) tick();
    base = got.size();
    riseBase = holdRises;
    for (int i = 0; i < 6; i++) begin
      in_data = 16'h1001 + 16'(i);
      in_valid = 1'b1;
      tick();
      if (i == 3) checkOutput("bp_ready_after4", {63'h0, in_ready}, 64'h1);
      if (i == 4) begin
        checkOutput("bp_ready_after5", {63'h0, in_ready}, 64'h0);
        checkOutput("bp_count_after5", {61'h0, fifo_count}, 64'h4);
      end
    end
    in_valid = 1'b0;
    checkOutput("bp_count_after6", {61'h0, fifo_count}, 64'h4);
    txEnable = 1'b1;
    waitBytes(base + 40, 600, "bp_bytes");
    repeat (40) tick();
    checkOutput("bp_total_bytes", 64'(got.size() - base), 64'd40);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_line%0d", i), lineFrom(base + 8*i), modelLine(16'h1001 + 16'(i)));
    end
    checkOutput("bp_hold_rises", 64'(holdRises - riseBase), 64'd1);

    // Twenty samples streamed through the four-entry FIFO.
    base = got.size();
    riseBase = holdRises;
    for (int i = 0; i < 20; i++) applyStimulus(16'(i));
    waitBytes(base + 160, 3000, "wrap_bytes");
    repeat (40) tick();
    checkOutput("wrap_total_bytes", 64'(got.size() - base), 64'd160);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("wrap_line%0d", i), lineFrom(base + 8*i), modelLine(16'(i)));
    end
    checkOutput("wrap_hold_rises", 64'(holdRises - riseBase), 64'd1);

    // LF-only instance.
    in_data = 16'h1234; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    begin
      int n = 0;
      while (got0.size() < 7 && n < 300) begin
        tick();
        n++;
      end
    end
    repeat (20) tick();
    checkOutput("lf_total_bytes", 64'(got0.size()), 64'd7);
    v0 = '0;
    for (int k = 0; k < 7; k++) v0 = {v0[55:0], (k < got0.size()) ? got0[k] : 8'h00};
    checkOutput("lf_line", v0, 64'h003078313233340A);
    checkOutput("lf_idle", {62'h0, tx_hold0, busy0}, 64'h2);

    // Reset in the middle of a line with two samples queued.
    txEnable = 1'b0;
    repeat (5) tick();
    base = got.size();
    applyStimulus(16'hABCD);
    applyStimulus(16'h1111);
    applyStimulus(16'h2222);
    checkOutput("mid_count_queued", {61'h0, fifo_count}, 64'h2);
    txEnable = 1'b1;
    waitBytes(base + 3, 100, "mid_three_bytes");
    txEnable = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_hold", {63'h0, tx_hold}, 64'h1);
    checkOutput("mid_rst_count", {61'h0, fifo_count}, 64'h0);
    checkOutput("mid_rst_busy", {63'h0, busy}, 64'h0);
    rst = 1'b0;
    repeat (5) tick();
    checkOutput("mid_partial_count", 64'(got.size() - base), 64'd3);
    checkOutput("mid_partial_bytes", {40'h0, got[base], got[base+1], got[base+2]}, 64'h307841);
    base = got.size();
    txEnable = 1'b1;
    applyStimulus(16'h0001);
    waitBytes(base + 8, 200, "mid_fresh_bytes");
    repeat (40) tick();
    checkOutput("mid_fresh_total", 64'(got.size() - base), 64'd8);
    checkOutput("mid_fresh_line", lineFrom(base), 64'h3078303030310D0A);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
